fetch_unit: RTL



---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit.sv | 100 ++++++++++
 2 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared core header: core-state, instruction-set and fetch constants.
// Imported by the fetch unit and the rest of the core.
package fetch_unit_pkg;

  localparam logic [31:0] NOOP_INSN = 32'h00000013;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    CORE_RESET = 2'b00,
    CORE_RUN   = 2'b01,
    CORE_HALT  = 2'b10
  } core_state_e;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'b00,
    FETCH_REQ  = 2'b01,
    FETCH_HOLD = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding req/ack bus,
// holds one word for decode, substitutes NOOP on error/timeout.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] NOOP    = NOOP_INSN,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        i_CLK,
  input  logic        i_RSTn,
  input  logic [31:0] i_PC,
  input  logic        i_EN,
  output logic [31:0] o_INSTRUCTION,
  output logic        o_INSTRUCTION_VALID,
  output logic        o_FETCH_FAULT,
  output logic        o_IBUS_REQ,
  output logic [31:0] o_IBUS_ADDR,
  input  logic        i_IBUS_ACK,
  input  logic [31:0] i_IBUS_RDATA,
  input  logic        i_IBUS_ERR
);

  fetch_state_e     state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic             fault_q, fault_d;
  logic [31:0]      addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_match;
  logic             expired;

  assign pc_match = (addr_q == i_PC);
  // TIMEOUT of zero leaves the counter free-running and never aborts
  assign expired  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  always_comb begin
    state_d             = state_q;
    instr_d             = instr_q;
    fault_d             = fault_q;
    addr_d              = addr_q;
    cnt_d               = cnt_q;
    o_IBUS_REQ          = 1'b0;
    o_INSTRUCTION_VALID = 1'b0;
    unique case (state_q)
      FETCH_IDLE: begin
        state_d = FETCH_REQ;
      end
      FETCH_REQ: begin
        o_IBUS_REQ = 1'b1;
        if (i_IBUS_ACK) begin
          instr_d = i_IBUS_ERR ? NOOP : i_IBUS_RDATA;
          fault_d = i_IBUS_ERR;
          addr_d  = i_PC;
          cnt_d   = '0;
          state_d = FETCH_HOLD;
        end else if (expired) begin
          instr_d = NOOP;
          fault_d = 1'b1;
          addr_d  = i_PC;
          cnt_d   = '0;
          state_d = FETCH_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FETCH_HOLD: begin
        o_INSTRUCTION_VALID = pc_match;
        if (!pc_match) begin
          state_d = FETCH_IDLE;
        end else if (i_EN) begin
          state_d = FETCH_REQ;
        end
      end
      default: begin
        state_d = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_CLK) begin
    if (!i_RSTn) begin
      state_q <= FETCH_IDLE;
      instr_q <= NOOP;
      fault_q <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_INSTRUCTION = instr_q;
  assign o_FETCH_FAULT = fault_q;
  assign o_IBUS_ADDR   = {i_PC[31:2], 2'b00};

endmodule
